// File: rtl/output_argmax_pkg.sv
// Shared fixed-point widths, types and argmax scan states.
// Optional OUTPUT_ARGMAX_MARGIN_EN adds a best-minus-second margin output.
package output_argmax_pkg;

  localparam int INTEGER_WIDTH  = 8;
  localparam int FRACTION_WIDTH = 8;

  typedef struct packed {
    logic [INTEGER_WIDTH-1:0]  integral;
    logic [FRACTION_WIDTH-1:0] fraction;
  } fixed_point_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } argmax_state_t;

endpackage

// File: rtl/output_argmax.sv
// Serial signed argmax over a snapshot of the network output vector.
// Optional OUTPUT_ARGMAX_MARGIN_EN adds class_margin (best - second best).
module output_argmax #(
  parameter int NUM_OUTPUTS    = 10,
  parameter int INTEGER_WIDTH  = output_argmax_pkg::INTEGER_WIDTH,
  parameter int FRACTION_WIDTH = output_argmax_pkg::FRACTION_WIDTH,
  localparam int INDEX_WIDTH   =
    (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
  input  logic clock,
  input  logic reset,
  input  logic outputs_ready,
  input  logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH]
               outputs [NUM_OUTPUTS],
  output logic busy,
  output logic class_valid,
  input  logic class_ready,
  output logic [INDEX_WIDTH-1:0] class_index,
  output logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH]
               class_value,
`ifdef OUTPUT_ARGMAX_MARGIN_EN
  output logic [INTEGER_WIDTH+FRACTION_WIDTH:0] class_margin,
`endif
  output logic overrun
);

  import output_argmax_pkg::*;

  localparam int W = INTEGER_WIDTH + FRACTION_WIDTH;

  typedef logic signed [W-1:0] val_t;

  localparam logic [INDEX_WIDTH-1:0] LAST =
    INDEX_WIDTH'(NUM_OUTPUTS - 1);

  argmax_state_t state_q, state_d;

  val_t snap_q [NUM_OUTPUTS];
  val_t snap_d [NUM_OUTPUTS];
  val_t best_q, best_d;
  val_t cval_q, cval_d;
  val_t cand;

  logic [INDEX_WIDTH-1:0] bidx_q, bidx_d;
  logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;
  logic [INDEX_WIDTH-1:0] cidx_q, cidx_d;

  logic prev_q;
  logic ovr_q, ovr_d;
  logic trig;
  logic gt;

`ifdef OUTPUT_ARGMAX_MARGIN_EN
  localparam val_t VAL_MIN = {1'b1, {(W-1){1'b0}}};
  val_t sec_q, sec_d;
  logic [W:0] mrg_q, mrg_d;
`endif

  // Trigger detection, scan step and result capture.
  always_comb begin
    trig    = outputs_ready && !prev_q;
    cand    = snap_q[ptr_q];
    gt      = cand > best_q;
    state_d = state_q;
    snap_d  = snap_q;
    best_d  = best_q;
    bidx_d  = bidx_q;
    ptr_d   = ptr_q;
    cidx_d  = cidx_q;
    cval_d  = cval_q;
    ovr_d   = ovr_q | (trig && state_q != IDLE);
`ifdef OUTPUT_ARGMAX_MARGIN_EN
    sec_d   = sec_q;
    mrg_d   = mrg_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (trig) begin
          for (int i = 0; i < NUM_OUTPUTS; i++)
            snap_d[i] = outputs[i];
          best_d = outputs[0];
          bidx_d = '0;
          ptr_d  = INDEX_WIDTH'(1);
`ifdef OUTPUT_ARGMAX_MARGIN_EN
          sec_d  = VAL_MIN;
`endif
          if (NUM_OUTPUTS == 1) begin
            state_d = DONE;
            cidx_d  = '0;
            cval_d  = outputs[0];
`ifdef OUTPUT_ARGMAX_MARGIN_EN
            mrg_d   = '0;
`endif
          end else begin
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        if (gt) begin
          best_d = cand;
          bidx_d = ptr_q;
`ifdef OUTPUT_ARGMAX_MARGIN_EN
          sec_d  = best_q;
        end else if (cand > sec_q) begin
          sec_d  = cand;
`endif
        end
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST) begin
          state_d = DONE;
          cidx_d  = bidx_d;
          cval_d  = best_d;
`ifdef OUTPUT_ARGMAX_MARGIN_EN
          mrg_d   = {best_d[W-1], best_d}
                  - {sec_d[W-1], sec_d};
`endif
        end
      end
      DONE: begin
        if (class_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      prev_q  <= 1'b0;
      ovr_q   <= 1'b0;
      cidx_q  <= '0;
      cval_q  <= '0;
`ifdef OUTPUT_ARGMAX_MARGIN_EN
      mrg_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      prev_q  <= outputs_ready;
      ovr_q   <= ovr_d;
      cidx_q  <= cidx_d;
      cval_q  <= cval_d;
`ifdef OUTPUT_ARGMAX_MARGIN_EN
      mrg_q   <= mrg_d;
`endif
    end
  end

  // Scan datapath, always loaded before use so no reset needed.
  always_ff @(posedge clock) begin
    snap_q <= snap_d;
    best_q <= best_d;
    bidx_q <= bidx_d;
    ptr_q  <= ptr_d;
`ifdef OUTPUT_ARGMAX_MARGIN_EN
    sec_q  <= sec_d;
`endif
  end

  assign busy        = state_q != IDLE;
  assign class_valid = state_q == DONE;
  assign class_index = cidx_q;
  assign class_value = cval_q;
  assign overrun     = ovr_q;
`ifdef OUTPUT_ARGMAX_MARGIN_EN
  assign class_margin = mrg_q;
`endif

endmodule

// File: doc/output_argmax.md
Name: output_argmax

Overview:
- Downstream of neural_network: consumes the final-layer vector (`outputs[]`, `outputs_ready`) and reduces it to a class decision.
- Snapshots the vector, scans it serially one element per cycle (one signed comparator), and presents the winning index and value on a valid/ready result port.
- Feeds the result/display logic; lets the network start the next inference while the scan runs.

Parameters:
- NUM_OUTPUTS, 10, number of network outputs (last layer size); must be ≥1.
- INTEGER_WIDTH, package INTEGER_WIDTH, integer bits of fixed-point values (incl. sign).
- FRACTION_WIDTH, package FRACTION_WIDTH, fraction bits of fixed-point values.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- outputs_ready  in  1  network result valid (level, may stay high).
- outputs  in  NUM_OUTPUTS x signed [INTEGER_WIDTH-1:-FRACTION_WIDTH]  network outputs.
- busy  out  1  snapshot held, scan or result pending.
- class_valid  out  1  result valid.
- class_ready  in  1  consumer accepts result.
- class_index  out  INDEX_WIDTH (= max(1,$clog2(NUM_OUTPUTS)))  argmax index.
- class_value  out  signed [INTEGER_WIDTH-1:-FRACTION_WIDTH]  maximum value.
- overrun  out  1  sticky: a result was dropped.

Behaviour:
- Reset (sync, active-high): state IDLE; busy=0, class_valid=0, class_index=0, class_value=0, overrun=0, edge register cleared to 0.
  - outputs_ready already high on the first cycle after reset counts as a new rising edge.
  - Reset mid-scan or mid-DONE abandons the result with no output.
- Trigger: rising edge of outputs_ready (current=1, registered previous=0). A level held high triggers once only.
- States: IDLE, SCAN, DONE.
- IDLE, trigger at cycle T:
  - Copy all `outputs` into an internal buffer.
  - Set best_val=outputs[0], best_idx=0, scan pointer=1.
  - Go to SCAN, or to DONE if NUM_OUTPUTS==1.
- SCAN: each cycle compare buf[ptr] against best_val as signed fixed-point.
  - Update best_val/best_idx only if strictly greater, so ties keep the lowest index.
  - When ptr==NUM_OUTPUTS-1, go to DONE after that compare.
- DONE: class_valid=1; class_index and class_value stable.
  - Handshake completes when class_valid && class_ready; next cycle back to IDLE, class_valid=0.
  - class_valid never drops without acceptance.
- Latency: class_valid first high at cycle T+NUM_OUTPUTS.
  - With class_ready held high, next trigger accepted at earliest T+NUM_OUTPUTS+1.
- busy=1 in SCAN and DONE.
- Trigger outside IDLE: dropped and overrun set to 1; overrun stays set until reset. The edge register still updates, so no deferred trigger.
- class_index/class_value hold their last value in IDLE.
- Arithmetic: pure signed compare, no widening needed.
  - Most-negative code is valid; an all-equal vector gives index 0.

Optional Feature:
- Macro OUTPUT_ARGMAX_MARGIN_EN.
- Defined:
  - Adds output port `class_margin`, unsigned, INTEGER_WIDTH+FRACTION_WIDTH+1 bits: best minus second-best value.
  - Second-best is tracked during SCAN; a value equal to best counts as second-best.
  - Zero when NUM_OUTPUTS==1.
  - Valid with class_valid; reset value 0.
  - Compare count and latency unchanged.
- Undefined: port and second-best tracking absent.

Decomposition:
- Shared package (existing include):
  - INTEGER_WIDTH, FRACTION_WIDTH.
  - fixed-point typedef with integral/fraction fields.
  - new argmax_state_t enum {IDLE, SCAN, DONE}.
- INDEX_WIDTH is a localparam in the module.
- No sub-module needed: the comparator is a single expression. Optional sub-module `fixed_point_max` (combinational compare/select) is acceptable if the margin logic is reused elsewhere.

Test Plan:
- NUM_OUTPUTS=10, outputs raw codes {3,-5,7,2,7,0,1,-1,4,6}, pulse outputs_ready at T → class_valid at T+10, class_index=2, class_value=7 (tie with index 4 keeps 2).
- All outputs = most-negative code → class_index=0, class_value=most-negative; with margin macro, class_margin=0.
- class_ready low for 5 cycles in DONE → class_valid, class_index, class_value stable all 5 cycles; returns to IDLE one cycle after acceptance.
- Second outputs_ready edge at T+4 → overrun=1 (sticky); first result still index 2; held-high outputs_ready produces no re-trigger.
- Reset asserted at T+5 mid-scan → next cycle busy=0, class_valid=0, overrun=0; outputs_ready held high through reset triggers a fresh scan after release.
- NUM_OUTPUTS=1, outputs={-2} → class_valid at T+1, index 0, value -2; with margin macro, margin {9,4,9,...} case yields class_margin=0 and {1,8,3} yields 5.
